// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, response and ALU port bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0] req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [5:0]           rsp_s;
    logic [3:0]           alu_a;
    logic [3:0]           alu_b;
    logic [3:0]           alu_i;
    logic                 alu_v;
    logic [5:0]           alu_s;
    logic                 busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_s,
        output req_ready, rsp_valid, rsp_id, rsp_s, alu_a, alu_b, alu_i, alu_v, busy
    );

    // Requester / ALU / environment side
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_s,
        input  req_ready, rsp_valid, rsp_id, rsp_s, alu_a, alu_b, alu_i, alu_v, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one 4-bit ALU between NUM_REQ requesters
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [3:0]      wait_cnt;
    logic [3:0]      alu_a_q;
    logic [3:0]      alu_b_q;
    logic [3:0]      alu_i_q;
    logic            alu_v_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [5:0]      rsp_s_q;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] probe_idx;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            probe_idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!grant_found && bus.req_valid[probe_idx]) begin
                grant_found = 1'b1;
                grant_idx   = probe_idx;
            end
        end
    end

    // Ready goes to the winner only while idle, so the handshake completes in the same cycle
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_found) begin
            bus.req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // Control FSM: grant, strobe the ALU for one cycle, wait out its latency, hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            wait_cnt    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_i_q     <= '0;
            alu_v_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_a_q    <= bus.req_a[4*grant_idx +: 4];
                        alu_b_q    <= bus.req_b[4*grant_idx +: 4];
                        alu_i_q    <= bus.req_op[4*grant_idx +: 4];
                        rsp_id_q   <= grant_idx;
                        last_grant <= grant_idx;
                        alu_v_q    <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_v_q  <= 1'b0;
                    wait_cnt <= 4'(ALU_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_s_q     <= bus.alu_s;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_i     = alu_i_q;
    assign bus.alu_v     = alu_v_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_s     = rsp_s_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 4-bit ALU (operands a/b, opcode i, valid strobe v, 6-bit result s) between NUM_REQ requesters.
- Round-robin grants one request at a time, drives the ALU for one cycle, waits ALU_LAT cycles and returns the result with the requester's ID.
- Sits between the requester agents and the ALU port.
- One operation in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, rsp_id width; must equal clog2(NUM_REQ).
- ALU_LAT, 1, cycles from alu_v cycle to the cycle alu_s is sampled (1..15).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  4*NUM_REQ  operand a, requester k at [4k+3:4k].
- req_b  input  4*NUM_REQ  operand b, same packing.
- req_op  input  4*NUM_REQ  ALU opcode, same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result accept.
- rsp_id  output  ID_W  index of the requester owning the result.
- rsp_s  output  6  ALU result.
- alu_a  output  4  operand a to ALU.
- alu_b  output  4  operand b to ALU.
- alu_i  output  4  opcode to ALU.
- alu_v  output  1  ALU operation strobe.
- alu_s  input  6  ALU result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; alu_a/b/i=0; alu_v=0; rsp_valid=0; rsp_id=0; rsp_s=0; busy=0; req_ready=0; last_grant=NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g is the first k with req_valid[k]=1, searching last_grant+1, +2, ... with wrap modulo NUM_REQ.
  - req_ready[g]=1 combinationally, same cycle; all other ready bits 0.
  - On the handshake edge: capture req_a/b/op slice g into alu_a/b/i and g into rsp_id; set last_grant=g; go to ISSUE.
  - No req_valid: stay in IDLE, req_ready=0.
- ISSUE:
  - alu_v=1 for exactly this one cycle; alu_a/b/i stable.
  - Load wait counter with ALU_LAT-1; go to WAIT.
- WAIT:
  - alu_v=0; alu_a/b/i hold their values until the next grant.
  - Counter decrements each cycle. In the cycle the counter reads 0, register alu_s into rsp_s and go to RESP.
  - ALU_LAT=1 therefore samples alu_s in the cycle after ISSUE.
- RESP:
  - rsp_valid=1; rsp_id and rsp_s held stable until the cycle with rsp_ready=1.
  - On that cycle go to IDLE; rsp_valid drops the next cycle.
  - No new grant in RESP, so req_ready=0 throughout.
- Latency: request accepted on edge T -> alu_v high in cycle T+1 -> alu_s sampled at T+1+ALU_LAT -> rsp_valid high from T+2+ALU_LAT. Minimum per-op throughput is ALU_LAT+3 cycles.
- Boundaries:
  - req_valid dropped before grant: no grant issued, no state change.
  - Requester k deasserting req_valid while others wait: skipped by the search.
  - Simultaneous valids: strictly round-robin; a requester holding valid is served within NUM_REQ grants.
  - rsp_ready held low indefinitely: stay in RESP, outputs stable, no new grant.
  - Reset asserted mid-operation: immediate return to reset values; the in-flight op is dropped with no response.
  - last_grant is updated only on a handshake.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> all outputs 0, busy=0; after release with no req_valid, req_ready stays 0 for 10 cycles.
- Single request (ALU_LAT=1): req_valid[2]=1, a=4'h5, b=4'h3, op=4'h0, ALU model s=a+b -> req_ready[2] the same cycle; alu_v one cycle with a=5, b=3; rsp_valid 3 cycles after accept with rsp_id=2, rsp_s=6'd8.
- Round-robin fairness: all four req_valid held high continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each requester served once per 4 grants.
- Response backpressure: rsp_ready=0 for 5 cycles during RESP with rsp_s=6'h2A -> rsp_valid, rsp_id and rsp_s stable; req_ready stays 0; release -> IDLE next cycle.
- Latency parameter: ALU_LAT=4 -> alu_v to rsp_valid spacing is 5 cycles; rsp_s equals alu_s driven 4 cycles after alu_v (e.g. 6'h3F).
- Reset mid-op: assert rst_n low during WAIT -> alu_v, rsp_valid and busy are 0 immediately; after release, requester 0 is granted first.
